// File: rtl/video_timing_gen.sv
// Raster timing generator: prescaled pixel tick drives h/v counters, syncs, visible and strobes.
// Outputs are registered from next-state counter values (0 latency skew); en=0 freezes all state.
module video_timing_gen #(
  parameter int H_VISIBLE = 200,
  parameter int H_FRONT   = 10,
  parameter int H_SYNC    = 32,
  parameter int H_BACK    = 22,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter int H_W       = 9,
  parameter int V_W       = 10,
  parameter int SYNC_POL  = 0,
  parameter int CLK_DIV   = 1
) (
  input  logic           clk,
  input  logic           rstN,
  input  logic           en,
  output logic [H_W-1:0] hCount,
  output logic [V_W-1:0] vCount,
  output logic           hSync,
  output logic           vSync,
  output logic           visible,
  output logic           pixTick,
  output logic           lineStart,
  output logic           frameStart
);

  localparam int   H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int   HS_START = H_VISIBLE + H_FRONT;
  localparam int   HS_END   = HS_START + H_SYNC - 1;
  localparam int   VS_START = V_VISIBLE + V_FRONT;
  localparam int   VS_END   = VS_START + V_SYNC - 1;
  localparam int   PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  if (H_TOTAL > (2 ** H_W)) begin : g_bad_h_w
    $error("H_TOTAL does not fit in H_W bits");
  end
  if (V_TOTAL > (2 ** V_W)) begin : g_bad_v_w
    $error("V_TOTAL does not fit in V_W bits");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end

  logic [PW-1:0]  presc;
  logic           tick;
  logic           h_last;
  logic           v_last;
  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  logic           hs_act;
  logic           vs_act;
  logic           vis_nxt;

  // Decode everything from the post-tick counter values so outputs line up with the counters.
  always_comb begin
    tick   = en && (presc == PW'(CLK_DIV - 1));
    h_last = (hCount == H_W'(H_TOTAL - 1));
    v_last = (vCount == V_W'(V_TOTAL - 1));
    h_nxt  = h_last ? '0 : hCount + 1'b1;
    v_nxt  = vCount;
    if (h_last) begin
      v_nxt = v_last ? '0 : vCount + 1'b1;
    end
    hs_act  = (h_nxt >= H_W'(HS_START)) && (h_nxt <= H_W'(HS_END));
    vs_act  = (v_nxt >= V_W'(VS_START)) && (v_nxt <= V_W'(VS_END));
    vis_nxt = (h_nxt < H_W'(H_VISIBLE)) && (v_nxt < V_W'(V_VISIBLE));
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      presc      <= '0;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= ~SYNC_ACT;
      vSync      <= ~SYNC_ACT;
      visible    <= 1'b1;
      pixTick    <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      pixTick    <= tick;
      lineStart  <= tick && h_last;
      frameStart <= tick && h_last && v_last;
      if (en) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        hCount  <= h_nxt;
        vCount  <= v_nxt;
        hSync   <= SYNC_ACT ? hs_act : ~hs_act;
        vSync   <= SYNC_ACT ? vs_act : ~vs_act;
        visible <= vis_nxt;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: four generator configurations run side by side against a per-clock reference.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic en = 1'b1;
  logic en3 = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // defaults
  logic [8:0] d_h; logic [9:0] d_v;
  logic d_hs, d_vs, d_vis, d_pt, d_ls, d_fs;
  video_timing_gen u_def (
    .clk(clk), .rstN(rstN), .en(en), .hCount(d_h), .vCount(d_v), .hSync(d_hs), .vSync(d_vs),
    .visible(d_vis), .pixTick(d_pt), .lineStart(d_ls), .frameStart(d_fs));

  // CLK_DIV=4
  logic [8:0] q_h; logic [9:0] q_v;
  logic q_hs, q_vs, q_vis, q_pt, q_ls, q_fs;
  video_timing_gen #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rstN(rstN), .en(en), .hCount(q_h), .vCount(q_v), .hSync(q_hs), .vSync(q_vs),
    .visible(q_vis), .pixTick(q_pt), .lineStart(q_ls), .frameStart(q_fs));

  // CLK_DIV=3 with its own enable
  logic [8:0] t_h; logic [9:0] t_v;
  logic t_hs, t_vs, t_vis, t_pt, t_ls, t_fs;
  video_timing_gen #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .rstN(rstN), .en(en3), .hCount(t_h), .vCount(t_v), .hSync(t_hs), .vSync(t_vs),
    .visible(t_vis), .pixTick(t_pt), .lineStart(t_ls), .frameStart(t_fs));

  // small raster, active-high syncs: H 8/2/3/3 = 16, V 6/1/2/1 = 10
  logic [3:0] s_h; logic [3:0] s_v;
  logic s_hs, s_vs, s_vis, s_pt, s_ls, s_fs;
  video_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                     .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .H_W(4), .V_W(4), .SYNC_POL(1)) u_small (
    .clk(clk), .rstN(rstN), .en(en), .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs),
    .visible(s_vis), .pixTick(s_pt), .lineStart(s_ls), .frameStart(s_fs));

  initial begin
    int e3, eh, ev, drop_left;
    bit t_tick, dropped;
    int m_def, m_q4, m_t3, m_small, t3_strobe_off;
    int def_ls_n, def_ls_first, def_ls_second, def_hs_n, def_hs_first, def_hs_last;
    int q4_pt_n, q4_ls_first, t3_pt_n, t3_ls_first;
    int s_fs_n, s_fs_first, s_ls_n, s_vs_n, s_vs_first, s_fs_coh;
    int waited;

    e3 = 0; drop_left = 0; dropped = 0;
    m_def = 0; m_q4 = 0; m_t3 = 0; m_small = 0; t3_strobe_off = 0;
    def_ls_n = 0; def_ls_first = -1; def_ls_second = -1; def_hs_n = 0; def_hs_first = -1; def_hs_last = -1;
    q4_pt_n = 0; q4_ls_first = -1; t3_pt_n = 0; t3_ls_first = -1;
    s_fs_n = 0; s_fs_first = -1; s_ls_n = 0; s_vs_n = 0; s_vs_first = -1; s_fs_coh = 0;

    // reset state, with clocks running
    repeat (3) @(negedge clk);
    check("rst_h", int'(d_h), 0);
    check("rst_v", int'(d_v), 0);
    check("rst_hsync_low_pol", int'(d_hs), 1);
    check("rst_vsync_low_pol", int'(d_vs), 1);
    check("rst_visible", int'(d_vis), 1);
    check("rst_strobes", int'({d_pt, d_ls, d_fs}), 0);
    check("rst_hsync_high_pol", int'(s_hs), 0);
    check("rst_vsync_high_pol", int'(s_vs), 0);
    rstN = 1'b1;

    for (int k = 1; k <= 2200; k++) begin
      @(posedge clk);
      t_tick = 1'b0;
      if (en3) begin
        e3++;
        t_tick = (e3 % 3 == 0);
      end
      @(negedge clk);

      // defaults, tick every clock
      eh = k % 264; ev = k / 264;
      if (int'(d_h) != eh || int'(d_v) != ev) m_def++;
      if (d_hs != !(eh >= 210 && eh <= 241) || d_vs != 1'b1) m_def++;
      if (d_vis != (eh < 200) || d_pt != 1'b1 || d_ls != (eh == 0) || d_fs != 1'b0) m_def++;
      if (d_ls) begin
        def_ls_n++;
        if (def_ls_first < 0) def_ls_first = k;
        else if (def_ls_second < 0) def_ls_second = k;
      end
      if (k < 264 && !d_hs) begin
        def_hs_n++;
        if (def_hs_first < 0) def_hs_first = int'(d_h);
        def_hs_last = int'(d_h);
      end

      // CLK_DIV=4
      eh = (k / 4) % 264; ev = (k / 4) / 264;
      if (int'(q_h) != eh || int'(q_v) != ev) m_q4++;
      if (q_hs != !(eh >= 210 && eh <= 241) || q_vis != (eh < 200)) m_q4++;
      if (q_pt != (k % 4 == 0) || q_ls != (k % 4 == 0 && eh == 0)) m_q4++;
      if (q_pt) q4_pt_n++;
      if (q_ls && q4_ls_first < 0) q4_ls_first = k;

      // CLK_DIV=3 with an enable gap
      eh = (e3 / 3) % 264; ev = (e3 / 3) / 264;
      if (int'(t_h) != eh || int'(t_v) != ev) m_t3++;
      if (t_hs != !(eh >= 210 && eh <= 241) || t_vis != (eh < 200)) m_t3++;
      if (t_pt != t_tick || t_ls != (t_tick && eh == 0)) m_t3++;
      if (!en3 && (t_pt || t_ls || t_fs)) t3_strobe_off++;
      if (t_pt) t3_pt_n++;
      if (t_ls && t3_ls_first < 0) t3_ls_first = k;

      // small raster, active-high
      eh = k % 16; ev = (k / 16) % 10;
      if (int'(s_h) != eh || int'(s_v) != ev) m_small++;
      if (s_hs != (eh >= 10 && eh <= 12) || s_vs != (ev >= 7 && ev <= 8)) m_small++;
      if (s_vis != (eh < 8 && ev < 6) || s_ls != (eh == 0) || s_fs != (eh == 0 && ev == 0)) m_small++;
      if (s_ls) s_ls_n++;
      if (s_fs) begin
        s_fs_n++;
        if (s_fs_first < 0) s_fs_first = k;
        if (!(s_ls && s_vis && s_h == 4'd0 && s_v == 4'd0)) s_fs_coh++;
      end
      if (k <= 160 && s_vs) begin
        s_vs_n++;
        if (s_vs_first < 0) s_vs_first = k;
      end

      // hold en3 low for 7 clocks, starting mid prescaler phase at hCount=150
      if (en3 && !dropped && e3 == 451) begin
        en3 = 1'b0; drop_left = 7; dropped = 1'b1;
      end else if (!en3) begin
        drop_left--;
        if (drop_left == 0) begin
          check("div3_h_frozen", int'(t_h), 150);
          check("div3_hsync_frozen", int'(t_hs), 1);
          en3 = 1'b1;
        end
      end
    end

    check("def_model_mismatches", m_def, 0);
    check("def_hsync_low_clocks", def_hs_n, 32);
    check("def_hsync_first_col", def_hs_first, 210);
    check("def_hsync_last_col", def_hs_last, 241);
    check("def_linestart_first", def_ls_first, 264);
    check("def_line_period", def_ls_second - def_ls_first, 264);
    check("def_linestart_count", def_ls_n, 8);
    check("div4_model_mismatches", m_q4, 0);
    check("div4_pixtick_count", q4_pt_n, 550);
    check("div4_line_period", q4_ls_first, 1056);
    check("div3_model_mismatches", m_t3, 0);
    check("div3_strobes_while_off", t3_strobe_off, 0);
    check("div3_pixtick_count", t3_pt_n, 731);
    check("div3_line_with_gap", t3_ls_first, 264 * 3 + 7);
    check("small_model_mismatches", m_small, 0);
    check("small_frame_period", s_fs_first, 160);
    check("small_framestart_count", s_fs_n, 13);
    check("small_linestart_count", s_ls_n, 137);
    check("small_frame_coherent", s_fs_coh, 0);
    check("small_vsync_high_clocks", s_vs_n, 32);
    check("small_vsync_first_clock", s_vs_first, 112);

    // asynchronous reset inside the hsync window
    waited = 0;
    while (d_h != 9'd220 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("wait_h220", int'(d_h), 220);
    check("h220_hsync_active", int'(d_hs), 0);
    #2 rstN = 1'b0;
    #1;
    check("arst_h", int'(d_h), 0);
    check("arst_v", int'(d_v), 0);
    check("arst_hsync", int'(d_hs), 1);
    check("arst_visible", int'(d_vis), 1);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("restart_h", int'(d_h), 1);
    check("restart_pixtick", int'(d_pt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
